// File: rtl/seq_decode_writeback.sv
// Decode and writeback stage of a sequential Y86-64 style processor.
// Holds the 15-entry program register file, derives source and destination
// register IDs from the fetched instruction, provides two combinational read
// ports plus a debug port, and commits execute/memory results on the clock.
module seq_decode_writeback (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        Cnd,
    input  logic        wb_en,
    input  logic [3:0]  dbg_sel,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] dbg_val,
    output logic [31:0] wb_count
);

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    logic [63:0] regs [0:14];
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        any_dst;

    // Derive source and destination register IDs from the instruction.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case statement can leave it unassigned (latch).
        src_a = R_NONE;
        src_b = R_NONE;
        dst_e = R_NONE;
        dst_m = R_NONE;
        case (icode)
            I_RRMOVQ: begin
                src_a = rA;
                if (Cnd) dst_e = rB;
            end
            I_IRMOVQ: dst_e = rB;
            I_RMMOVQ: begin
                src_a = rA;
                src_b = rB;
            end
            I_MRMOVQ: begin
                src_b = rB;
                dst_m = rA;
            end
            I_OPQ: begin
                src_a = rA;
                src_b = rB;
                dst_e = rB;
            end
            I_CALL: begin
                src_b = R_RSP;
                dst_e = R_RSP;
            end
            I_RET: begin
                src_a = R_RSP;
                src_b = R_RSP;
                dst_e = R_RSP;
            end
            I_PUSHQ: begin
                src_a = rA;
                src_b = R_RSP;
                dst_e = R_RSP;
            end
            I_POPQ: begin
                src_a = R_RSP;
                src_b = R_RSP;
                dst_e = R_RSP;
                dst_m = rA;
            end
            default: ;
        endcase
    end

    assign any_dst = (dst_e != R_NONE) || (dst_m != R_NONE);

    // Read ports; ID 0xF means no register and reads as zero. Reset clears
    // the array, so all ports also read zero while rst_n is low.
    assign valA    = (src_a   == R_NONE) ? 64'd0 : regs[src_a];
    assign valB    = (src_b   == R_NONE) ? 64'd0 : regs[src_b];
    assign dbg_val = (dbg_sel == R_NONE) ? 64'd0 : regs[dbg_sel];

    // Commit execute and memory results; the valM write is issued last so it
    // wins when both destinations name the same register (popq %rsp).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file must read zero immediately on reset, so
            // it is built from resettable flops rather than an un-reset RAM.
            for (int i = 0; i < 15; i++) regs[i] <= 64'd0;
        end else if (wb_en) begin
            // NOTE: non-blocking assignments make the later valM write override
            // the valE write within the same edge without a race.
            if (dst_e != R_NONE) regs[dst_e] <= valE;
            if (dst_m != R_NONE) regs[dst_m] <= valM;
        end
    end

    // Count edges on which at least one register was committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count <= 32'd0;
        end else if (wb_en && any_dst) begin
            wb_count <= wb_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_seq_decode_writeback.sv
// Directed bench for seq_decode_writeback: each instruction is applied on a
// falling edge, read ports are checked before the rising edge, and register
// state is checked through the debug port after it.
module tb_seq_decode_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        Cnd;
    logic        wb_en;
    logic [3:0]  dbg_sel;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] dbg_val;
    logic [31:0] wb_count;

    int vectors = 0;
    int miscompares = 0;

    seq_decode_writeback dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .icode    (icode),
        .rA       (rA),
        .rB       (rB),
        .valE     (valE),
        .valM     (valM),
        .Cnd      (Cnd),
        .wb_en    (wb_en),
        .dbg_sel  (dbg_sel),
        .valA     (valA),
        .valB     (valB),
        .dbg_val  (dbg_val),
        .wb_count (wb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic cnd, input logic en);
        icode = ic;
        rA    = ra;
        rB    = rb;
        valE  = ve;
        valM  = vm;
        Cnd   = cnd;
        wb_en = en;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        wb_en = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] idx, input logic [63:0] exp);
        dbg_sel = idx;
        #1;
        check(tag, dbg_val, exp);
    endtask

    initial begin
        rst_n   = 1'b0;
        dbg_sel = 4'h2;
        apply(4'h2, 4'h2, 4'h3, 64'h99, 64'h77, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("reset_valA", valA, 64'd0);
        check("reset_valB", valB, 64'd0);
        check("reset_count", {32'd0, wb_count}, 64'd0);
        check_reg("reset_reg3", 4'h3, 64'd0);
        wb_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // irmovq $0x10, %rdx
        apply(4'h3, 4'hF, 4'h2, 64'h10, 64'h0, 1'b0, 1'b1);
        check("irmov_valA", valA, 64'd0);
        step();
        check_reg("irmov_reg2", 4'h2, 64'h10);
        check("irmov_count", {32'd0, wb_count}, 64'd1);

        // cmovXX %rdx, %rbx, condition false then true
        apply(4'h2, 4'h2, 4'h3, 64'h10, 64'h0, 1'b0, 1'b1);
        check("cmov_valA", valA, 64'h10);
        step();
        check_reg("cmov_nc_reg3", 4'h3, 64'd0);
        check("cmov_nc_count", {32'd0, wb_count}, 64'd1);
        apply(4'h2, 4'h2, 4'h3, 64'h10, 64'h0, 1'b1, 1'b1);
        step();
        check_reg("cmov_c_reg3", 4'h3, 64'h10);
        check("cmov_c_count", {32'd0, wb_count}, 64'd2);

        // rsp = 0x100, rdx = 0x1234
        apply(4'h3, 4'hF, 4'h4, 64'h100, 64'h0, 1'b0, 1'b1);
        step();
        apply(4'h3, 4'hF, 4'h2, 64'h1234, 64'h0, 1'b0, 1'b1);
        step();
        check("setup_count", {32'd0, wb_count}, 64'd4);

        // pushq %rdx
        apply(4'hA, 4'h2, 4'hF, 64'hF8, 64'h0, 1'b0, 1'b1);
        check("push_valA", valA, 64'h1234);
        check("push_valB", valB, 64'h100);
        step();
        check_reg("push_rsp", 4'h4, 64'hF8);
        check("push_count", {32'd0, wb_count}, 64'd5);

        // popq %rsp: valM beats valE
        apply(4'hB, 4'h4, 4'hF, 64'h108, 64'h55, 1'b0, 1'b1);
        check("pop_valA", valA, 64'hF8);
        check("pop_valB", valB, 64'hF8);
        step();
        check_reg("pop_rsp", 4'h4, 64'h55);
        check("pop_count", {32'd0, wb_count}, 64'd6);

        // OPq %rbx, %rcx with writeback disabled, then enabled
        apply(4'h6, 4'h3, 4'h1, 64'h7, 64'h0, 1'b0, 1'b0);
        check("opq_valA", valA, 64'h10);
        check("opq_valB", valB, 64'h0);
        step();
        check_reg("opq_off_reg1", 4'h1, 64'd0);
        check("opq_off_count", {32'd0, wb_count}, 64'd6);
        apply(4'h6, 4'h3, 4'h1, 64'h7, 64'h0, 1'b0, 1'b1);
        step();
        check_reg("opq_on_reg1", 4'h1, 64'h7);
        check("opq_on_count", {32'd0, wb_count}, 64'd7);

        // mrmovq D(%rdx), %rbp
        apply(4'h5, 4'h5, 4'h2, 64'h0, 64'hABCD, 1'b0, 1'b1);
        check("mrmov_valB", valB, 64'h1234);
        step();
        check_reg("mrmov_reg5", 4'h5, 64'hABCD);
        check("mrmov_count", {32'd0, wb_count}, 64'd8);

        // unknown icode: no reads, no write, no count
        apply(4'hC, 4'h6, 4'h6, 64'hDEAD, 64'hBEEF, 1'b1, 1'b1);
        check("unk_valA", valA, 64'd0);
        check("unk_valB", valB, 64'd0);
        step();
        check_reg("unk_reg6", 4'h6, 64'd0);
        check("unk_count", {32'd0, wb_count}, 64'd8);

        // nop with writeback enabled does not count
        apply(4'h1, 4'hF, 4'hF, 64'h1, 64'h1, 1'b0, 1'b1);
        step();
        check("nop_count", {32'd0, wb_count}, 64'd8);
        check_reg("dbg_none", 4'hF, 64'd0);

        // asynchronous reset mid-cycle with a write pending
        apply(4'h3, 4'hF, 4'h2, 64'h77, 64'h0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        dbg_sel = 4'h2;
        #1;
        check("arst_reg2", dbg_val, 64'd0);
        check("arst_count", {32'd0, wb_count}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_reg("arst_hold_reg2", 4'h2, 64'd0);
        check_reg("arst_hold_reg5", 4'h5, 64'd0);
        wb_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // first write after reset release
        apply(4'h3, 4'hF, 4'h2, 64'h42, 64'h0, 1'b0, 1'b1);
        step();
        check_reg("post_reg2", 4'h2, 64'h42);
        check("post_count", {32'd0, wb_count}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
